// File: rtl/t02_wb_arbiter_manager.sv
// Wishbone B4 classic master shared by NUM_CH request channels.
// Round-robin grant, per-transfer byte select, ERR_I handling and an ACK timeout.
`timescale 1ns/1ps
module t02_wb_arbiter_manager #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_read,
  input  logic [NUM_CH-1:0]          req_write,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0] req_sel,
  output logic [NUM_CH*DATA_W-1:0]   rdata,
  output logic [NUM_CH-1:0]          busy,
  output logic [NUM_CH-1:0]          err,
  output logic [ADDR_W-1:0]          ADR_O,
  output logic [DATA_W-1:0]          DAT_O,
  output logic [DATA_W/8-1:0]        SEL_O,
  output logic                       WE_O,
  output logic                       STB_O,
  output logic                       CYC_O,
  input  logic [DATA_W-1:0]          DAT_I,
  input  logic                       ACK_I,
  input  logic                       ERR_I
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 32'd0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1);

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   cur;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_CH-1:0]  done;
  logic [NUM_CH-1:0]  req_any;
  logic               gnt_valid;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;
  logic               timeout_hit;

  assign req_any     = req_read | req_write;
  assign busy        = req_any & ~done;
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (cnt == CNT_LAST);

  // Round-robin search starting just after the previous grant.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % NUM_CH);
      if (!gnt_valid && req_any[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_CH - 1);
      cur        <= '0;
      cnt        <= '0;
      done       <= '0;
      err        <= '0;
      rdata      <= '0;
      ADR_O      <= '0;
      DAT_O      <= '0;
      SEL_O      <= '0;
      WE_O       <= 1'b0;
      STB_O      <= 1'b0;
      CYC_O      <= 1'b0;
    end else begin
      done <= '0;
      err  <= '0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            cur        <= gnt_idx;
            last_grant <= gnt_idx;
            ADR_O      <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
            DAT_O      <= req_wdata[gnt_idx*DATA_W +: DATA_W];
            SEL_O      <= req_sel[gnt_idx*SEL_W +: SEL_W];
            WE_O       <= req_write[gnt_idx];
            CYC_O      <= 1'b1;
            STB_O      <= 1'b1;
            cnt        <= '0;
            state      <= BUS;
          end
        end
        // ERR_I outranks ACK_I; the timeout only fires on a silent slave.
        BUS: begin
          if (ERR_I || (!ACK_I && timeout_hit)) begin
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            err[cur]  <= 1'b1;
            done[cur] <= 1'b1;
            state     <= DONE;
          end else if (ACK_I) begin
            CYC_O     <= 1'b0;
            STB_O     <= 1'b0;
            done[cur] <= 1'b1;
            if (!WE_O) rdata[cur*DATA_W +: DATA_W] <= DAT_I;
            state     <= DONE;
          end else if (TIMEOUT_CYCLES != 32'd0) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_t02_wb_arbiter_manager.sv
// Directed bench for t02_wb_arbiter_manager: table of single transfers plus
// round-robin and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_t02_wb_arbiter_manager;

  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TO  = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCH-1:0]      req_read, req_write;
  logic [NCH*AW-1:0]   req_addr;
  logic [NCH*DW-1:0]   req_wdata;
  logic [NCH*SW-1:0]   req_sel;
  logic [NCH*DW-1:0]   rdata;
  logic [NCH-1:0]      busy, err;
  logic [AW-1:0]       ADR_O;
  logic [DW-1:0]       DAT_O;
  logic [SW-1:0]       SEL_O;
  logic                WE_O, STB_O, CYC_O;
  logic [DW-1:0]       DAT_I;
  logic                ACK_I, ERR_I;

  t02_wb_arbiter_manager #(
    .NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_read(req_read), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_sel(req_sel),
    .rdata(rdata), .busy(busy), .err(err),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O),
    .STB_O(STB_O), .CYC_O(CYC_O),
    .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          ch;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] din;
    int          ack_at;    // CYC cycle (1-based) in which ACK_I is driven, 0 = never
    int          err_at;    // CYC cycle in which ERR_I is driven, 0 = never
    int          exp_cyc;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  // One transfer on one channel; the slave model answers per the vector.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc_hi = 0;
    bit ended  = 1'b0;
    req_read  = '0;
    req_write = '0;
    if (v.wr) req_write[v.ch] = 1'b1;
    else      req_read[v.ch]  = 1'b1;
    req_addr[v.ch*AW +: AW]  = v.addr;
    req_wdata[v.ch*DW +: DW] = v.wdata;
    req_sel[v.ch*SW +: SW]   = v.sel;
    DAT_I = v.din;
    for (int c = 0; c < 20 && !ended; c++) begin
      @(negedge clk);
      if (c == 0) check($sformatf("v%0d_latency", idx), 128'(CYC_O), 128'(1));
      if (CYC_O) begin
        cyc_hi++;
        check($sformatf("v%0d_bus_fields", idx), 128'({ADR_O, DAT_O, SEL_O, WE_O, STB_O}),
              128'({v.addr, v.wdata, v.sel, v.wr, 1'b1}));
        check($sformatf("v%0d_busy_in_bus", idx), 128'(busy[v.ch]), 128'(1));
        if (cyc_hi == 1) begin
          req_addr[v.ch*AW +: AW]  = ~v.addr;
          req_wdata[v.ch*DW +: DW] = ~v.wdata;
          req_sel[v.ch*SW +: SW]   = ~v.sel;
        end
        ACK_I = (cyc_hi == v.ack_at);
        ERR_I = (cyc_hi == v.err_at);
      end else if (cyc_hi > 0) begin
        ACK_I = 1'b0;
        ERR_I = 1'b0;
        check($sformatf("v%0d_cyc_len", idx), 128'(cyc_hi), 128'(v.exp_cyc));
        check($sformatf("v%0d_busy_done", idx), 128'(busy[v.ch]), 128'(0));
        check($sformatf("v%0d_err_pulse", idx), 128'(err[v.ch]), 128'(v.exp_err));
        ended = 1'b1;
      end
    end
    if (!ended) begin
      n_checks++;
      n_fail++;
      $display("FAIL v%0d_complete: transfer did not finish, CYC cycles seen %0d, expected %0d",
               idx, cyc_hi, v.exp_cyc);
      ACK_I = 1'b0;
      ERR_I = 1'b0;
    end
    req_read  = '0;
    req_write = '0;
    @(negedge clk);
    check($sformatf("v%0d_err_clear", idx), 128'(err), 128'(0));
    check($sformatf("v%0d_rdata", idx), 128'(rdata[v.ch*DW +: DW]), 128'(v.exp_rdata));
    check($sformatf("v%0d_idle", idx), 128'(CYC_O), 128'(0));
  endtask

  initial begin
    vecs[0] = '{ch:0, wr:1'b0, addr:32'h3000_0010, wdata:32'h0, sel:4'hF, din:32'hCAFE_F00D,
                ack_at:3, err_at:0, exp_cyc:3, exp_err:1'b0, exp_rdata:32'hCAFE_F00D};
    vecs[1] = '{ch:1, wr:1'b1, addr:32'h3000_0020, wdata:32'h1234_5678, sel:4'b0011, din:32'hFFFF_0000,
                ack_at:1, err_at:0, exp_cyc:1, exp_err:1'b0, exp_rdata:32'h0};
    vecs[2] = '{ch:1, wr:1'b0, addr:32'h3000_0040, wdata:32'h0, sel:4'hF, din:32'hA5A5_0001,
                ack_at:2, err_at:0, exp_cyc:2, exp_err:1'b0, exp_rdata:32'hA5A5_0001};
    vecs[3] = '{ch:0, wr:1'b0, addr:32'h3000_0080, wdata:32'h0, sel:4'hF, din:32'hDEAD_BEEF,
                ack_at:0, err_at:0, exp_cyc:8, exp_err:1'b1, exp_rdata:32'hCAFE_F00D};
    vecs[4] = '{ch:1, wr:1'b0, addr:32'h3000_00C0, wdata:32'h0, sel:4'hF, din:32'hFFFF_FFFF,
                ack_at:1, err_at:1, exp_cyc:1, exp_err:1'b1, exp_rdata:32'hA5A5_0001};
    vecs[5] = '{ch:0, wr:1'b1, addr:32'h3000_0100, wdata:32'h0BAD_F00D, sel:4'b1000, din:32'h7777_7777,
                ack_at:0, err_at:2, exp_cyc:2, exp_err:1'b1, exp_rdata:32'hCAFE_F00D};
    vecs[6] = '{ch:0, wr:1'b0, addr:32'h3000_0104, wdata:32'h0, sel:4'hF, din:32'h0000_0001,
                ack_at:1, err_at:0, exp_cyc:1, exp_err:1'b0, exp_rdata:32'h0000_0001};

    rst = 1'b1;
    req_read = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_sel = '0;
    DAT_I = '0; ACK_I = 1'b0; ERR_I = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_bus", 128'({ADR_O, DAT_O, SEL_O, WE_O, STB_O, CYC_O}), 128'(0));
    check("reset_rdata", 128'(rdata), 128'(0));
    check("reset_err_busy", 128'({err, busy}), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Both channels held, immediate ACK: ch0, ch1, ch0, ch1 starting from reset.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req_addr  = {32'h0000_0200, 32'h0000_0100};
    req_wdata = '0;
    req_sel   = '1;
    DAT_I     = 32'h5555_AAAA;
    req_read  = 2'b11;
    for (int k = 0; k < 12; k++) begin
      int ch;
      @(negedge clk);
      ch = (k / 3) % 2;
      case (k % 3)
        0: begin
          check($sformatf("rr%0d_cyc", k), 128'(CYC_O), 128'(1));
          check($sformatf("rr%0d_grant_adr", k), 128'(ADR_O), 128'(ch == 0 ? 32'h100 : 32'h200));
          check($sformatf("rr%0d_busy", k), 128'(busy), 128'(2'b11));
          ACK_I = 1'b1;
        end
        1: begin
          ACK_I = 1'b0;
          check($sformatf("rr%0d_done_cyc", k), 128'(CYC_O), 128'(0));
          check($sformatf("rr%0d_done_busy", k), 128'(busy), 128'(ch == 0 ? 2'b10 : 2'b01));
        end
        default: begin
          check($sformatf("rr%0d_idle_cyc", k), 128'(CYC_O), 128'(0));
          check($sformatf("rr%0d_idle_busy", k), 128'(busy), 128'(2'b11));
          if (k == 11) req_read = '0;
        end
      endcase
    end
    @(negedge clk);
    check("rr_rdata", 128'(rdata), 128'({32'h5555_AAAA, 32'h5555_AAAA}));
    check("rr_quiet", 128'(CYC_O), 128'(0));

    // Reset in the second BUS cycle of a ch0 write; ch1 waits throughout.
    req_addr  = {32'h3000_0400, 32'h3000_0300};
    req_write = 2'b01;
    req_read  = 2'b10;
    @(negedge clk);
    check("rst_mid_grant", 128'({CYC_O, WE_O, ADR_O}), 128'({1'b1, 1'b1, 32'h3000_0300}));
    @(negedge clk);
    check("rst_mid_bus2", 128'(CYC_O), 128'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_drop", 128'({CYC_O, STB_O, WE_O}), 128'(0));
    check("rst_mid_err", 128'(err), 128'(0));
    check("rst_mid_rdata", 128'(rdata), 128'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_regrant", 128'({CYC_O, WE_O, ADR_O}), 128'({1'b1, 1'b1, 32'h3000_0300}));
    ACK_I = 1'b1;
    @(negedge clk);
    ACK_I = 1'b0;
    check("rst_mid_done", 128'({CYC_O, err, busy}), 128'({1'b0, 2'b00, 2'b10}));
    req_read  = '0;
    req_write = '0;
    repeat (2) @(negedge clk);
    check("final_idle", 128'(CYC_O), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
